pool2x2_stream: RTL and testbench
=================================

# pool2x2_stream

2x2 max-pooling stage on the 63-bit RGB feature stream, placed directly upstream of the `mid_bram` row-buffer stage. It consumes row bursts of a W×H feature map, with three signed 21-bit channels packed per word. It emits (W/2)×(H/2) pooled rows as contiguous de-framed bursts, so the downstream row-buffer addressing (address increments on each de cycle and clears when de is low) works unchanged. A single half-row line buffer holds the partial vertical maxima.

## Interface
- `IMG_W`, 56: input row length in pixels; must be even, ≥4.
- `IMG_H`, 56: input rows per frame; must be even.
- `CH_W`, 21: bits per channel; channels are signed two's complement.
- `clk`  in  1  clock; all logic is posedge.
- `RESET`  in  1  reset, synchronous, active-high.
- `frame_start`  in  1  1-cycle pulse that clears the row/column counters, the FSM and `err`.
- `de_in`  in  1  input data enable; high for exactly IMG_W consecutive cycles per row.
- `in`  in  63  pixel word: [20:0] R, [41:21] G, [62:42] B.
- `de_out`  out  1  output enable; high for exactly IMG_W/2 consecutive cycles per pooled row.
- `out`  out  63  pooled word, same packing as `in`.
- `frame_done`  out  1  1-cycle pulse in the cycle after the last `de_out` of pooled row H/2−1.
- `err`  out  1  sticky flag for an input-row overlap with a drain burst.

## Operation
- FSM states: S_EVEN, S_ODD, S_DRAIN. Reset state is S_EVEN.
  - S_EVEN → S_ODD on a de_in falling edge.
  - S_ODD → S_DRAIN on a de_in falling edge.
  - S_DRAIN → S_EVEN after IMG_W/2 output cycles.
- Column counter `col` counts de_in-high cycles and clears when de_in is low.
- Horizontal max: at odd `col`, `hmax` = per-channel signed max of the pixel at `col` and the pixel at `col`−1.
- S_EVEN: line buffer entry `col>>1` is written with `hmax`.
- S_ODD: line buffer entry `col>>1` is overwritten with the per-channel max of the stored entry and `hmax`.
- S_DRAIN: entries 0..IMG_W/2−1 are read in order and presented on `out` with `de_out`=1.
- Row counter `row` increments on each de_in falling edge and wraps IMG_H−1 → 0.
  - Each wrap marks end of frame; `frame_done` fires after the drain that follows the wrap.
- Comparisons are signed per channel and never widen; `out` channels equal input channel values exactly (no rounding).
- Overlap: if de_in rises while in S_DRAIN:
  - `err` is set and stays set until RESET or `frame_start`.
  - The drain completes unaltered.
  - The incoming row's data is discarded, but the row still counts toward `row` and even/odd parity.
- `frame_start` together with `de_in`=1 in the same cycle: the counters clear and that cycle is taken as `col`=0 of row 0.
- RESET or `frame_start` mid-drain aborts the burst; `de_out`=0 from the next cycle.

## Timing
- Reset values: `de_out`=0, `out`=0, `frame_done`=0, `err`=0. All counters are 0 and the FSM is in S_EVEN.
- Input is sampled on posedge; `in` must be stable across the edge.
- Line buffer has 1 write port and 1 read port with 1-cycle read latency. The read-modify-write path in S_ODD is pipelined so that a write lands 2 cycles after its pair completes.
- Drain latency: first `de_out`=1 occurs 3 cycles after the first cycle with de_in=0 that ends an odd row.
- Burst length is exactly IMG_W/2, with no gaps.
- Minimum inter-row gap after an odd row is IMG_W/2+4 cycles; a smaller gap triggers the overlap rule.
- The gap after an even row only needs to be 1 cycle.

## Configuration
- `POOL_RELU_EN` defined: each output channel is clamped to 0 when negative, as a registered stage inside the existing output register (no extra latency).
- `POOL_RELU_EN` undefined: signed maxima pass through unchanged.

## Structure
- Package `pool_pkg` holds:
  - constants `NCH`=3, `CH_W`=21, `WORD_W`=63;
  - the FSM state enum;
  - a per-channel signed max function over a packed word.
- Sub-module `pool_line_buf` is a simple dual-port RAM of depth IMG_W/2 × 63 bits with synchronous read, inferable as block RAM.
- The top level holds the FSM, counters, pair/compare pipeline, output register and the optional ReLU.

## Test plan
- Bench uses IMG_W=4, IMG_H=4.
  - R channel row0 = {1,5,−3,2}, row1 = {4,0,7,−9}, G=B=0 → burst of 2 words, R = {5,7}.
  - `de_out` rises 3 cycles after the row1 de_in falls.
- All inputs −5 in every channel, with and without `POOL_RELU_EN` → `out` channels equal −5 (0x1FFFFB) without the macro, 0 with it.
- Full 4×4 frame followed by a second frame → 2 bursts per frame.
  - `frame_done` pulses once, in the cycle after the 2nd burst ends.
  - `row` wraps and the second frame's output matches the first.
- Row2 de_in starting 2 cycles after row1 ends → `err`=1, the drain burst is intact, and row2's data is discarded.
  - The next even/odd pairing follows the row count.
- RESET asserted on the 2nd `de_out` cycle → `de_out`=0 and `out`=0 next cycle; a fresh frame afterward pools correctly.
- Channel extremes: R = {0x0FFFFF, 0x100000} (+max/−min) → `out` R = 0x0FFFFF, with G and B unaffected.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared constants, FSM state type and per-channel helpers for the 2x2 pooling stage.
// Words carry three signed channels: [20:0] R, [41:21] G, [62:42] B.
package pool_pkg;

    localparam int NCH    = 3;
    localparam int CH_W   = 21;
    localparam int WORD_W = NCH * CH_W;

    typedef enum logic [1:0] {
        S_EVEN  = 2'd0,
        S_ODD   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] max_word(input logic [WORD_W-1:0] a,
                                                   input logic [WORD_W-1:0] b);
        logic [WORD_W-1:0] m;
        m = '0;
        for (int c = 0; c < NCH; c++) begin
            m[c*CH_W +: CH_W] = ($signed(a[c*CH_W +: CH_W]) > $signed(b[c*CH_W +: CH_W]))
                                ? a[c*CH_W +: CH_W] : b[c*CH_W +: CH_W];
        end
        return m;
    endfunction

    function automatic logic [WORD_W-1:0] relu_word(input logic [WORD_W-1:0] a);
        logic [WORD_W-1:0] m;
        m = a;
        for (int c = 0; c < NCH; c++) begin
            if (a[c*CH_W + CH_W - 1])
                m[c*CH_W +: CH_W] = '0;
        end
        return m;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer: simple dual-port RAM, one write and one synchronous read port.
// No reset on the array or read register so it maps onto block RAM.
module pool_line_buf #(
    parameter int DEPTH  = 28,
    parameter int DATA_W = 63,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pool2x2_stream.sv
// pool2x2_stream: 2x2 signed max-pooling of a 3-channel row stream into half-size de-framed bursts.
// Optional macro POOL_RELU_EN clamps negative output channels to zero inside the output register.
//
// state   | meaning
// S_EVEN  | even input row: store horizontal pair maxima in the line buffer
// S_ODD   | odd input row: merge pair maxima into the stored entries
// S_DRAIN | emit the pooled row; a row starting in this state is discarded
module pool2x2_stream
    import pool_pkg::*;
#(
    parameter int IMG_W = 56,
    parameter int IMG_H = 56
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              frame_start,
    input  logic              de_in,
    input  logic [WORD_W-1:0] in,
    output logic              de_out,
    output logic [WORD_W-1:0] out,
    output logic              frame_done,
    output logic              err
);

    localparam int HALF_W    = IMG_W / 2;
    localparam int CW        = $clog2(IMG_W);
    localparam int AW        = $clog2(HALF_W);
    localparam int RW        = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DRAIN_LEN = HALF_W + 3;
    localparam int DW        = $clog2(DRAIN_LEN);

    state_t            r_state, w_state_nxt, w_state_eff;
    logic [CW-1:0]     r_col, w_col;
    logic [RW-1:0]     r_row;
    logic [DW-1:0]     r_dcnt, w_drain_pos;
    logic              r_de_d, r_discard, r_err, r_eof;
    logic              w_rise, w_fall, w_overlap, w_pix, w_pair;
    logic              w_rd_drain, w_rd_odd;
    logic [AW-1:0]     w_rd_addr;
    logic [WORD_W-1:0] w_hmax, w_rdata, w_out_nxt;

    logic [WORD_W-1:0] r_prev, r_h_val, r_w_val;
    logic [AW-1:0]     r_h_idx, r_w_idx;
    logic              r_h_vld, r_h_odd, r_w_vld;

    logic              r_rd_vld, r_rd_last, r_de_out, r_out_last, r_frame_done;
    logic [WORD_W-1:0] r_out;

    // frame_start with de_in high makes this cycle pixel 0 of row 0 in S_EVEN
    assign w_state_eff = frame_start ? S_EVEN : r_state;
    assign w_col       = frame_start ? '0 : r_col;
    assign w_rise      = de_in & (frame_start | ~r_de_d);
    assign w_fall      = ~de_in & r_de_d & ~frame_start;
    assign w_overlap   = w_rise & (w_state_eff == S_DRAIN);
    assign w_pix       = de_in & ~w_overlap & (frame_start | ~r_discard);
    assign w_pair      = w_pix & w_col[0];
    assign w_hmax      = max_word(in, r_prev);
    assign w_drain_pos = DW'(DRAIN_LEN - 1) - r_dcnt;

    always_ff @(posedge clk) begin
        if (RESET)
            r_state <= S_EVEN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (frame_start) begin
            w_state_nxt = S_EVEN;
        end else begin
            case (r_state)
                S_EVEN:  if (w_fall) w_state_nxt = S_ODD;
                S_ODD:   if (w_fall) w_state_nxt = S_DRAIN;
                S_DRAIN: if (r_dcnt == '0) w_state_nxt = S_EVEN;
                default: w_state_nxt = S_EVEN;
            endcase
        end
    end

    always_comb begin
        w_rd_drain = 1'b0;
        w_rd_odd   = 1'b0;
        case (r_state)
            S_DRAIN: w_rd_drain = (w_drain_pos < DW'(HALF_W)) && !frame_start;
            S_ODD:   w_rd_odd   = w_pair && !frame_start;
            default: ;
        endcase
    end

    assign w_rd_addr = w_rd_drain ? w_drain_pos[AW-1:0] : w_col[CW-1:1];

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_col     <= '0;
            r_row     <= '0;
            r_de_d    <= 1'b0;
            r_discard <= 1'b0;
            r_err     <= 1'b0;
            r_eof     <= 1'b0;
        end else begin
            r_de_d <= de_in;
            r_col  <= de_in ? w_col + 1'b1 : '0;
            if (frame_start)
                r_row <= '0;
            else if (w_fall)
                r_row <= (r_row == RW'(IMG_H - 1)) ? '0 : r_row + 1'b1;
            if (frame_start)
                r_discard <= 1'b0;
            else if (w_overlap)
                r_discard <= 1'b1;
            else if (!de_in)
                r_discard <= 1'b0;
            if (frame_start)
                r_err <= 1'b0;
            else if (w_overlap)
                r_err <= 1'b1;
            if (frame_start)
                r_eof <= 1'b0;
            else if (w_fall && r_row == RW'(IMG_H - 1))
                r_eof <= 1'b1;
            else if (r_state == S_DRAIN && r_dcnt == '0)
                r_eof <= 1'b0;
        end
    end

    // drain timer also covers the pipeline tail, so rows rising inside it are overlaps
    always_ff @(posedge clk) begin
        if (RESET || frame_start)
            r_dcnt <= '0;
        else if (r_state == S_ODD && w_fall)
            r_dcnt <= DW'(DRAIN_LEN - 1);
        else if (r_dcnt != '0)
            r_dcnt <= r_dcnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_prev  <= '0;
            r_h_vld <= 1'b0;
            r_h_odd <= 1'b0;
            r_h_idx <= '0;
            r_h_val <= '0;
            r_w_vld <= 1'b0;
            r_w_idx <= '0;
            r_w_val <= '0;
        end else begin
            if (w_pix && !w_col[0])
                r_prev <= in;
            r_h_vld <= w_pair;
            r_h_odd <= (w_state_eff == S_ODD);
            r_h_idx <= w_col[CW-1:1];
            r_h_val <= w_hmax;
            r_w_vld <= r_h_vld;
            r_w_idx <= r_h_idx;
            r_w_val <= r_h_odd ? max_word(w_rdata, r_h_val) : r_h_val;
        end
    end

    pool_line_buf #(
        .DEPTH  (HALF_W),
        .DATA_W (WORD_W),
        .AW     (AW)
    ) u_line_buf (
        .clk     (clk),
        .i_we    (r_w_vld),
        .i_waddr (r_w_idx),
        .i_wdata (r_w_val),
        .i_re    (w_rd_drain | w_rd_odd),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata)
    );

`ifdef POOL_RELU_EN
    assign w_out_nxt = relu_word(w_rdata);
`else
    assign w_out_nxt = w_rdata;
`endif

    always_ff @(posedge clk) begin
        if (RESET || frame_start) begin
            r_rd_vld     <= 1'b0;
            r_rd_last    <= 1'b0;
            r_de_out     <= 1'b0;
            r_out        <= '0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_rd_vld     <= w_rd_drain;
            r_rd_last    <= w_rd_drain && r_eof && (w_drain_pos == DW'(HALF_W - 1));
            r_de_out     <= r_rd_vld;
            r_out        <= r_rd_vld ? w_out_nxt : '0;
            r_out_last   <= r_rd_vld & r_rd_last;
            r_frame_done <= r_out_last;
        end
    end

    assign de_out     = r_de_out;
    assign out        = r_out;
    assign frame_done = r_frame_done;
    assign err        = r_err;

endmodule

// File: tb/tb_pool2x2_stream.sv
// Directed bench for pool2x2_stream at IMG_W=4, IMG_H=4; expected values are hand-computed.
// Honours POOL_RELU_EN when the same macro is defined for the build.
module tb_pool2x2_stream;

    typedef logic [3:0][62:0] row_t;
    typedef logic [1:0][62:0] pair_t;

    typedef struct {
        string name;
        row_t  r0;
        row_t  r1;
        pair_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        frame_start = 1'b0;
    logic        de_in = 1'b0;
    logic [62:0] in_w = '0;
    logic        de_out;
    logic [62:0] out_w;
    logic        frame_done;
    logic        err;

    logic [62:0] obs_w [$];
    int          obs_c [$];
    int          fd_c [$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        vt [4];

    always #5 clk = ~clk;

    pool2x2_stream #(.IMG_W(4), .IMG_H(4)) dut (
        .clk         (clk),
        .RESET       (RESET),
        .frame_start (frame_start),
        .de_in       (de_in),
        .in          (in_w),
        .de_out      (de_out),
        .out         (out_w),
        .frame_done  (frame_done),
        .err         (err)
    );

    function automatic logic [62:0] pk(input int r, input int g, input int b);
        logic [20:0] rr, gg, bb;
        rr = r[20:0];
        gg = g[20:0];
        bb = b[20:0];
        return {bb, gg, rr};
    endfunction

    function automatic row_t pk4(input logic [62:0] a, input logic [62:0] b,
                                 input logic [62:0] c, input logic [62:0] d);
        row_t v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v;
    endfunction

    function automatic logic [62:0] relu_m(input logic [62:0] w);
        logic [62:0] r;
        r = w;
`ifdef POOL_RELU_EN
        for (int c = 0; c < 3; c++)
            if (w[c*21 + 20]) r[c*21 +: 21] = '0;
`endif
        return r;
    endfunction

    function automatic logic [62:0] word_at(input int i);
        return (i < obs_w.size()) ? obs_w[i] : '1;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < obs_c.size()) ? obs_c[i] : -1;
    endfunction

    task automatic chk(input string nm, input logic [62:0] act, input logic [62:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // sample this cycle's outputs at the negedge, then drive this cycle's inputs
    task automatic step(input logic rst, input logic fs, input logic de, input logic [62:0] w);
        @(negedge clk);
        cyc++;
        if (de_out) begin
            obs_w.push_back(out_w);
            obs_c.push_back(cyc);
        end
        if (frame_done)
            fd_c.push_back(cyc);
        RESET       = rst;
        frame_start = fs;
        de_in       = de;
        in_w        = w;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic send_row(input row_t px);
        for (int p = 0; p < 4; p++) step(1'b0, 1'b0, 1'b1, px[p]);
    endtask

    task automatic clear_obs();
        obs_w.delete();
        obs_c.delete();
        fd_c.delete();
    endtask

    initial begin
        int   f;
        row_t r2, r3, big, r3b;

        vt[0].name = "basic";
        vt[0].r0   = pk4(pk(1,0,0), pk(5,0,0), pk(-3,0,0), pk(2,0,0));
        vt[0].r1   = pk4(pk(4,0,0), pk(0,0,0), pk(7,0,0), pk(-9,0,0));
        vt[0].exp  = {pk(7,0,0), pk(5,0,0)};
        vt[1].name = "neg5";
        vt[1].r0   = pk4(pk(-5,-5,-5), pk(-5,-5,-5), pk(-5,-5,-5), pk(-5,-5,-5));
        vt[1].r1   = vt[1].r0;
        vt[1].exp  = {pk(-5,-5,-5), pk(-5,-5,-5)};
        vt[2].name = "extreme";
        vt[2].r0   = pk4(pk('h0FFFFF,7,'h0FFFFF), pk('h100000,7,'h0FFFFF),
                         pk('h100000,7,'h0FFFFF), pk('h100000,7,'h0FFFFF));
        vt[2].r1   = pk4(pk('h100000,7,'h0FFFFF), pk('h100000,7,'h0FFFFF),
                         pk('h100000,7,'h0FFFFF), pk('h100000,7,'h0FFFFF));
        vt[2].exp  = {pk('h100000,7,'h0FFFFF), pk('h0FFFFF,7,'h0FFFFF)};
        vt[3].name = "mixed";
        vt[3].r0   = pk4(pk(0,-1,10), pk(0,-2,-10), pk(0,-3,0), pk(0,-4,0));
        vt[3].r1   = pk4(pk(0,-8,-20), pk(0,-7,11), pk(0,-6,-1), pk(0,-5,-1));
        vt[3].exp  = {pk(0,-3,0), pk(0,-1,11)};

        r2  = pk4(pk(-1,0,0), pk(-2,0,0), pk(100,0,0), pk(-100,0,0));
        r3  = pk4(pk(-4,0,0), pk(-3,0,0), pk(-50,0,0), pk(99,0,0));
        big = pk4(pk(1000,1000,0), pk(1000,1000,0), pk(1000,1000,0), pk(1000,1000,0));
        r3b = pk4(pk(-7,0,0), pk(-8,0,0), pk(20,0,0), pk(6,0,0));

        // reset state
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("reset de_out", {62'd0, de_out}, 63'd0);
        chk("reset out", out_w, '0);
        chk("reset frame_done", {62'd0, frame_done}, 63'd0);
        chk("reset err", {62'd0, err}, 63'd0);
        idle(2);

        // table: one even/odd row pair per vector
        for (int i = 0; i < 4; i++) begin
            clear_obs();
            step(1'b0, 1'b1, 1'b0, '0);
            send_row(vt[i].r0);
            idle(1);
            send_row(vt[i].r1);
            step(1'b0, 1'b0, 1'b0, '0);
            f = cyc;
            idle(12);
            chk_i({vt[i].name, " burst len"}, obs_w.size(), 2);
            chk({vt[i].name, " word0"}, word_at(0), relu_m(vt[i].exp[0]));
            chk({vt[i].name, " word1"}, word_at(1), relu_m(vt[i].exp[1]));
            chk_i({vt[i].name, " latency"}, cyc_at(0) - f, 3);
            chk_i({vt[i].name, " contiguous"}, cyc_at(1) - cyc_at(0), 1);
            chk_i({vt[i].name, " no frame_done"}, fd_c.size(), 0);
            chk({vt[i].name, " err"}, {62'd0, err}, 63'd0);
        end

        // two full frames back to back, minimum legal gap after odd rows
        clear_obs();
        step(1'b0, 1'b1, 1'b0, '0);
        for (int fr = 0; fr < 2; fr++) begin
            send_row(vt[0].r0); idle(1);
            send_row(vt[0].r1); idle(6);
            send_row(r2);       idle(1);
            send_row(r3);       idle(6);
        end
        idle(4);
        chk_i("frames burst words", obs_w.size(), 8);
        for (int fr = 0; fr < 2; fr++) begin
            chk("frame w0", word_at(fr*4 + 0), relu_m(pk(5,0,0)));
            chk("frame w1", word_at(fr*4 + 1), relu_m(pk(7,0,0)));
            chk("frame w2", word_at(fr*4 + 2), relu_m(pk(-1,0,0)));
            chk("frame w3", word_at(fr*4 + 3), relu_m(pk(100,0,0)));
        end
        chk_i("frame_done count", fd_c.size(), 2);
        chk_i("frame_done1 timing", (fd_c.size() > 0) ? fd_c[0] : -1, cyc_at(3) + 1);
        chk_i("frame_done2 timing", (fd_c.size() > 1) ? fd_c[1] : -1, cyc_at(7) + 1);
        chk("min gap err", {62'd0, err}, 63'd0);

        // overlapping row: starts 2 cycles after an odd row ends
        clear_obs();
        step(1'b0, 1'b1, 1'b0, '0);
        send_row(vt[0].r0); idle(1);
        send_row(vt[0].r1);
        step(1'b0, 1'b0, 1'b0, '0);
        f = cyc;
        idle(1);
        send_row(big);
        chk("overlap err set", {62'd0, err}, 63'd1);
        idle(1);
        send_row(r3b);
        idle(12);
        chk_i("overlap words", obs_w.size(), 4);
        chk("overlap drain w0", word_at(0), pk(5,0,0));
        chk("overlap drain w1", word_at(1), pk(7,0,0));
        chk_i("overlap drain latency", cyc_at(0) - f, 3);
        chk("after discard w0", word_at(2), pk(5,0,0));
        chk("after discard w1", word_at(3), pk(20,0,0));
        chk_i("overlap frame_done", fd_c.size(), 1);
        chk("err sticky", {62'd0, err}, 63'd1);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("err cleared", {62'd0, err}, 63'd0);

        // RESET on the second de_out cycle
        clear_obs();
        step(1'b0, 1'b1, 1'b0, '0);
        send_row(vt[0].r0); idle(1);
        send_row(vt[0].r1);
        step(1'b0, 1'b0, 1'b0, '0);
        f = cyc;
        idle(3);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("2nd de_out before reset", {62'd0, de_out}, 63'd1);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("de_out after reset", {62'd0, de_out}, 63'd0);
        chk("out after reset", out_w, '0);
        idle(8);
        chk_i("aborted burst words", obs_w.size(), 2);
        clear_obs();
        send_row(vt[0].r0); idle(1);
        send_row(vt[0].r1); idle(12);
        chk_i("post-reset words", obs_w.size(), 2);
        chk("post-reset w0", word_at(0), pk(5,0,0));
        chk("post-reset w1", word_at(1), pk(7,0,0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
